// File: rtl/program_loader.sv
// Program loader: writes a valid/ready byte stream into the program RAM at
// consecutive addresses from a base, stalling the CPU until the load is over.
module program_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              cpu_hold,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W:0]     rem_q, rem_d;
    logic                accept_s;
    logic                in_ready_q, busy_q, cpu_hold_q, done_q, mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;

    // Next-state, pointer/count update and byte acceptance
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        rem_d    = rem_q;
        accept_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (length != {(ADDR_W+1){1'b0}}) begin
                        ptr_d   = base_addr;
                        rem_d   = length;
                        state_d = LOAD;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                // abort wins over a byte offered in the same cycle
                if (abort) begin
                    state_d = IDLE;
                end else if (in_valid && in_ready_q) begin
                    accept_s = 1'b1;
                    ptr_d    = ptr_q + ADDR_W'(1);
                    rem_d    = rem_q - (ADDR_W+1)'(1);
                    if (rem_q == (ADDR_W+1)'(1)) begin
                        state_d = FLUSH;
                    end else begin
                        state_d = LOAD;
                    end
                end else begin
                    state_d = LOAD;
                end
            end
            FLUSH: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, counters and registered outputs decoded from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= {ADDR_W{1'b0}};
            rem_q       <= {(ADDR_W+1){1'b0}};
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            cpu_hold_q  <= 1'b0;
            done_q      <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= {DATA_W{1'b0}};
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rem_q      <= rem_d;
            in_ready_q <= (state_d == LOAD);
            busy_q     <= (state_d == LOAD) || (state_d == FLUSH);
            cpu_hold_q <= (state_d != IDLE);
            done_q     <= (state_d == DONE);
            mem_we_q   <= accept_s;
            if (accept_s) begin
                mem_addr_q  <= ptr_q;
                mem_wdata_q <= in_data;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign cpu_hold  = cpu_hold_q;
    assign done      = done_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: scenario tasks with inline checks and a
// RAM model that records every write the loader issues.
module tb_program_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] base_addr = 8'h00;
    logic [8:0] length = 9'd0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready, mem_we, busy, cpu_hold, done;
    logic [7:0] mem_addr, mem_wdata;

    int checks = 0;
    int failures = 0;

    logic [7:0] ram [0:255];
    int         we_cnt = 0;

    program_loader #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .base_addr(base_addr), .length(length), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
        .cpu_hold(cpu_hold), .done(done)
    );

    always #5 clk = ~clk;

    // RAM write port model
    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
            we_cnt        <= we_cnt + 1;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, mem_we, busy, cpu_hold, done, mem_addr, mem_wdata} !== 21'd0)
            begin failures++; $display("FAIL reset_async: got %h expected 0", {in_ready, mem_we, busy, cpu_hold, done, mem_addr, mem_wdata}); end
        start = 1'b1; length = 9'd4;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, mem_we, busy, cpu_hold, done} !== 5'b00000)
            begin failures++; $display("FAIL reset_hold: got %b expected 00000", {in_ready, mem_we, busy, cpu_hold, done}); end
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        checks++;
        if ({in_ready, busy, cpu_hold, done} !== 4'b0000)
            begin failures++; $display("FAIL reset_idle: got %b expected 0000", {in_ready, busy, cpu_hold, done}); end
    endtask

    task automatic test_basic;
        logic [7:0] d [4];
        int w0;
        d = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        w0 = we_cnt;
        base_addr = 8'h10; length = 9'd4; start = 1'b1; in_valid = 1'b1; in_data = d[0];
        tick;
        checks++;
        if ({in_ready, busy, cpu_hold, mem_we, done} !== 5'b11100)
            begin failures++; $display("FAIL basic_start: got %b expected 11100", {in_ready, busy, cpu_hold, mem_we, done}); end
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_data = d[i];
            tick;
            checks++;
            if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 8'h10 + i[7:0], d[i]})
                begin failures++; $display("FAIL basic_write%0d: got we=%b a=%h d=%h expected we=1 a=%h d=%h", i, mem_we, mem_addr, mem_wdata, 8'h10 + i[7:0], d[i]); end
            checks++;
            if ({in_ready, busy, cpu_hold, done} !== {(i < 3), 1'b1, 1'b1, 1'b0})
                begin failures++; $display("FAIL basic_ctrl%0d: got %b expected %b", i, {in_ready, busy, cpu_hold, done}, {(i < 3), 3'b110}); end
        end
        in_valid = 1'b0;
        tick;
        checks++;
        if ({in_ready, busy, cpu_hold, done, mem_we} !== 5'b00110)
            begin failures++; $display("FAIL basic_done: got %b expected 00110", {in_ready, busy, cpu_hold, done, mem_we}); end
        tick;
        checks++;
        if ({in_ready, busy, cpu_hold, done, mem_we} !== 5'b00000)
            begin failures++; $display("FAIL basic_idle: got %b expected 00000", {in_ready, busy, cpu_hold, done, mem_we}); end
        checks++;
        if ({ram[8'h10], ram[8'h11], ram[8'h12], ram[8'h13]} !== 32'hA1A2A3A4 || we_cnt - w0 != 4)
            begin failures++; $display("FAIL basic_ram: got %h%h%h%h cnt=%0d expected a1a2a3a4 cnt=4", ram[8'h10], ram[8'h11], ram[8'h12], ram[8'h13], we_cnt - w0); end
    endtask

    task automatic test_wrap;
        logic [7:0] a [3];
        a = '{8'hFE, 8'hFF, 8'h00};
        base_addr = 8'hFE; length = 9'd3; start = 1'b1; in_valid = 1'b1;
        tick;
        base_addr = 8'h77;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'h01 + i[7:0];
            if (i == 2) start = 1'b0;
            tick;
            checks++;
            if ({mem_we, mem_addr, mem_wdata} !== {1'b1, a[i], 8'h01 + i[7:0]})
                begin failures++; $display("FAIL wrap_write%0d: got we=%b a=%h d=%h expected we=1 a=%h d=%h", i, mem_we, mem_addr, mem_wdata, a[i], 8'h01 + i[7:0]); end
        end
        in_valid = 1'b0;
        tick;
        checks++;
        if ({done, mem_we} !== 2'b10)
            begin failures++; $display("FAIL wrap_done: got done=%b we=%b expected done=1 we=0", done, mem_we); end
        tick;
        checks++;
        if ({busy, cpu_hold, done} !== 3'b000)
            begin failures++; $display("FAIL wrap_idle: got %b expected 000 (held start must not queue)", {busy, cpu_hold, done}); end
    endtask

    task automatic test_back_pressure;
        logic [7:0] d [3];
        logic       pat [6];
        int         k;
        d   = '{8'hC1, 8'hC2, 8'hC3};
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        k   = 0;
        base_addr = 8'h20; length = 9'd3; start = 1'b1;
        tick;
        start = 1'b0;
        for (int c = 0; c < 6; c++) begin
            in_valid = pat[c];
            in_data  = pat[c] ? d[k] : 8'hEE;
            tick;
            if (pat[c]) begin
                checks++;
                if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 8'h20 + k[7:0], d[k]})
                    begin failures++; $display("FAIL bp_write%0d: got we=%b a=%h d=%h expected we=1 a=%h d=%h", c, mem_we, mem_addr, mem_wdata, 8'h20 + k[7:0], d[k]); end
                k++;
            end else begin
                checks++;
                if (mem_we !== 1'b0)
                    begin failures++; $display("FAIL bp_idle%0d: got we=%b expected 0", c, mem_we); end
            end
        end
        in_valid = 1'b0;
        tick;
        checks++;
        if ({done, mem_we, ram[8'h20], ram[8'h21], ram[8'h22]} !== {2'b10, 24'hC1C2C3})
            begin failures++; $display("FAIL bp_done: got done=%b we=%b ram=%h%h%h expected done=1 we=0 ram=c1c2c3", done, mem_we, ram[8'h20], ram[8'h21], ram[8'h22]); end
        tick;
    endtask

    task automatic test_abort;
        logic [7:0] keep;
        keep = ram[8'h32];
        base_addr = 8'h30; length = 9'd5; start = 1'b1;
        tick;
        start = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_data = 8'hD1 + i[7:0];
            tick;
            checks++;
            if ({mem_we, mem_addr} !== {1'b1, 8'h30 + i[7:0]})
                begin failures++; $display("FAIL abort_write%0d: got we=%b a=%h expected we=1 a=%h", i, mem_we, mem_addr, 8'h30 + i[7:0]); end
        end
        in_data = 8'hD3; abort = 1'b1;
        tick;
        abort = 1'b0; in_valid = 1'b0;
        checks++;
        if ({in_ready, busy, cpu_hold, done, mem_we} !== 5'b00000)
            begin failures++; $display("FAIL abort_drop: got %b expected 00000", {in_ready, busy, cpu_hold, done, mem_we}); end
        tick;
        checks++;
        if ({done, mem_we} !== 2'b00 || ram[8'h31] !== 8'hD2 || ram[8'h32] !== keep)
            begin failures++; $display("FAIL abort_ram: got done=%b we=%b r31=%h r32=%h expected done=0 we=0 r31=d2 r32=%h", done, mem_we, ram[8'h31], ram[8'h32], keep); end
    endtask

    task automatic test_zero_length;
        int w0;
        w0 = we_cnt;
        base_addr = 8'h60; length = 9'd0; start = 1'b1; in_valid = 1'b1; in_data = 8'h99;
        tick;
        start = 1'b0;
        checks++;
        if ({in_ready, busy, cpu_hold, done, mem_we} !== 5'b00110)
            begin failures++; $display("FAIL zero_done: got %b expected 00110", {in_ready, busy, cpu_hold, done, mem_we}); end
        tick;
        in_valid = 1'b0;
        checks++;
        if ({in_ready, busy, cpu_hold, done, mem_we} !== 5'b00000 || we_cnt != w0)
            begin failures++; $display("FAIL zero_idle: got %b writes=%0d expected 00000 writes=0", {in_ready, busy, cpu_hold, done, mem_we}, we_cnt - w0); end
    endtask

    task automatic test_reset_mid_load;
        base_addr = 8'h50; length = 9'd4; start = 1'b1;
        tick;
        start = 1'b0; in_valid = 1'b1;
        in_data = 8'hE1; tick;
        in_data = 8'hE2; tick;
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, mem_we, busy, cpu_hold, done, mem_addr, mem_wdata} !== 21'd0)
            begin failures++; $display("FAIL midreset_async: got %h expected 0", {in_ready, mem_we, busy, cpu_hold, done, mem_addr, mem_wdata}); end
        #2;
        rst_n = 1'b1;
        tick;
        checks++;
        if ({busy, done, mem_we} !== 3'b000)
            begin failures++; $display("FAIL midreset_idle: got %b expected 000", {busy, done, mem_we}); end
        base_addr = 8'h40; length = 9'd1; start = 1'b1;
        tick;
        start = 1'b0; in_valid = 1'b1; in_data = 8'h55;
        tick;
        in_valid = 1'b0;
        checks++;
        if ({mem_we, mem_addr, mem_wdata, in_ready} !== {1'b1, 8'h40, 8'h55, 1'b0})
            begin failures++; $display("FAIL midreset_write: got we=%b a=%h d=%h rdy=%b expected we=1 a=40 d=55 rdy=0", mem_we, mem_addr, mem_wdata, in_ready); end
        tick;
        checks++;
        if ({done, mem_we, ram[8'h40]} !== {2'b10, 8'h55})
            begin failures++; $display("FAIL midreset_done: got done=%b we=%b r40=%h expected done=1 we=0 r40=55", done, mem_we, ram[8'h40]); end
        tick;
    endtask

    initial begin
        #2;
        test_reset;
        test_basic;
        test_wrap;
        test_back_pressure;
        test_abort;
        test_zero_length;
        test_reset_mid_load;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
